hazard_scoreboard: RTL

//  Parametrised hazard/forwarding controller for the 5-stage pipelined ASIP (next gen).

---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard_sat_counter.sv | 22 ++
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ASIP hazard/forwarding scoreboard: op classes, forward selects,
// and the shadow pipeline entry kept for EX/MEM/WB.
package hazard_scoreboard_pkg;

  localparam int REG_W_MAX = 8;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_MULTI = 2'd2
  } op_cls_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Register fields are sized for the largest supported file and zero-extended on entry.
  typedef struct packed {
    logic                 v;
    logic                 wr;
    logic [REG_W_MAX-1:0] rd;
    op_cls_e              cls;
    logic [REG_W_MAX-1:0] rs;
    logic [REG_W_MAX-1:0] rt;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '{v: 1'b0, wr: 1'b0, rd: '0, cls: OP_ALU, rs: '0, rt: '0};

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage decode fields and EX redirect in, pipeline control and forward selects out.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int PERF_W = 16
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wr;
  logic [REG_W-1:0]  id_rd;
  op_cls_e           id_cls;
  logic              id_jump;
  logic              ex_redirect;

  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              exmem_bubble;
  logic              ex_hold;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_cls, id_jump, ex_redirect,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_bubble, ex_hold, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_cls, id_jump, ex_redirect,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_bubble, ex_hold, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
// Synchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shadows EX/MEM/WB destinations, drives stall/flush/bubble,
// multi-cycle EX hold and EX operand forward selects. Outputs are combinational from state + ID.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int NREG    = 16,
  parameter int MUL_LAT = 3,
  parameter int ZERO_R0 = 1,
  parameter int PERF_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  hazard_scoreboard_if.slave sb
);
  localparam int REG_W = $clog2(NREG);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  if (DATA_W < 1 || REG_W > REG_W_MAX || MUL_LAT < 1) begin : g_bad_params
    $error("hazard_scoreboard: illegal parameter set");
  end

  hz_entry_t        r_ex, r_mem, r_wb;
  hz_entry_t        w_id, w_ex_nxt, w_mem_nxt;
  logic [CNT_W-1:0] r_ex_cnt, w_cnt_nxt;
  logic             w_hold, w_load_use, w_pc_we, w_flush, w_idb;
  logic             w_unused;

  function automatic logic f_match(hz_entry_t e, logic [REG_W_MAX-1:0] r);
    return e.v && e.wr && (e.rd == r) && !((ZERO_R0 != 0) && (r == '0));
  endfunction

  // A load still in MEM has no data yet; it only becomes forwardable from WB.
  function automatic logic [1:0] f_fwd(hz_entry_t mem, hz_entry_t wb, logic [REG_W_MAX-1:0] r);
    if (f_match(mem, r) && (mem.cls != OP_LOAD)) return FWD_MEM;
    if (f_match(wb, r)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    w_id = '{v: sb.id_valid, wr: sb.id_wr, rd: REG_W_MAX'(sb.id_rd), cls: sb.id_cls,
             rs: REG_W_MAX'(sb.id_rs), rt: REG_W_MAX'(sb.id_rt)};
    w_hold     = (r_ex_cnt != '0);
    w_load_use = (r_ex.cls == OP_LOAD) &&
                 ((sb.id_use_rs && f_match(r_ex, w_id.rs)) ||
                  (sb.id_use_rt && f_match(r_ex, w_id.rt)));
    w_pc_we    = 1'b1;
    w_flush    = 1'b0;
    w_idb      = 1'b0;
    w_ex_nxt   = w_id;
    w_mem_nxt  = r_ex;
    w_cnt_nxt  = (sb.id_valid && (sb.id_cls == OP_MULTI)) ? CNT_W'(MUL_LAT - 1) : '0;
    if (w_hold) begin
      w_pc_we   = 1'b0;
      w_ex_nxt  = r_ex;
      w_mem_nxt = HZ_BUBBLE;
      w_cnt_nxt = r_ex_cnt - 1'b1;
    end else if (sb.ex_redirect) begin
      w_flush   = 1'b1;
      w_idb     = 1'b1;
      w_ex_nxt  = HZ_BUBBLE;
      w_cnt_nxt = '0;
    end else if (w_load_use) begin
      // Jump in ID is deliberately ignored here; it is presented again next cycle.
      w_pc_we   = 1'b0;
      w_idb     = 1'b1;
      w_ex_nxt  = HZ_BUBBLE;
      w_cnt_nxt = '0;
    end else if (sb.id_jump) begin
      w_flush   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ex     <= HZ_BUBBLE;
      r_mem    <= HZ_BUBBLE;
      r_wb     <= HZ_BUBBLE;
      r_ex_cnt <= '0;
    end else begin
      r_ex     <= w_ex_nxt;
      r_mem    <= w_mem_nxt;
      r_wb     <= r_mem;
      r_ex_cnt <= w_cnt_nxt;
    end
  end

  assign sb.pc_we        = w_pc_we;
  assign sb.ifid_we      = w_pc_we;
  assign sb.ifid_flush   = w_flush;
  assign sb.idex_bubble  = w_idb;
  assign sb.exmem_bubble = w_hold;
  assign sb.ex_hold      = w_hold;
  assign sb.fwd_a        = f_fwd(r_mem, r_wb, r_ex.rs);
  assign sb.fwd_b        = f_fwd(r_mem, r_wb, r_ex.rt);
  assign w_unused        = ^{r_wb.cls, r_wb.rs, r_wb.rt};

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (!w_pc_we),
    .o_cnt   (sb.stall_cnt)
  );

  // Branches are single-cycle ALU ops, so a redirect can never coincide with a multi-cycle hold.
  a_no_redirect_in_hold : assert property (@(posedge i_clk) disable iff (!i_reset)
    !(w_hold && sb.ex_redirect))
    else $error("ex_redirect asserted while EX is held by a multi-cycle op");
endmodule
